// File: rtl/lbp_stream.sv
// Streaming 3x3 Local Binary Pattern engine.
// Reads a gray image once in raster order and writes one LBP code per pixel
// position in raster order. Border positions get code 0, or no write at all.
module lbp_stream #(
  parameter int IMG_W       = 128,
  parameter int IMG_H       = 128,
  parameter int PIX_W       = 8,
  parameter int ADDR_W      = 14,
  parameter int BORDER_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [PIX_W-1:0]  gray_data,
  input  logic              mode,
  input  logic [PIX_W-1:0]  thr,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam int unsigned N  = IMG_W * IMG_H;
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  state_t             state;
  logic               req_d;      // gray_data carries a pixel this cycle
  logic               mode_q;
  logic [PIX_W-1:0]   thr_q;

  // position of the pixel arriving on gray_data
  logic [RW-1:0]      in_r;
  logic [CW-1:0]      in_c;
  // position/address of the next output slot
  logic [RW-1:0]      out_r;
  logic [CW-1:0]      out_c;
  logic [ADDR_W-1:0]  out_addr;

  // lb0 holds the previous row, lb1 the row before it, indexed by column
  logic [PIX_W-1:0]   lb0 [IMG_W];
  logic [PIX_W-1:0]   lb1 [IMG_W];

  // w1_* is the column one left of the incoming one, w0_* two left
  logic [PIX_W-1:0]   w0_t, w0_m, w0_b;
  logic [PIX_W-1:0]   w1_t, w1_m, w1_b;

  logic [PIX_W-1:0]   col_t, col_m;
  logic [PIX_W:0]     limit;
  logic [7:0]         code;
  logic               in_slot;
  logic               slot;
  logic               interior;
  logic               last_slot;

  function automatic logic ge(input logic [PIX_W-1:0] n, input logic [PIX_W:0] lim);
    return {1'b0, n} >= lim;
  endfunction

  // Window assembly and slot bookkeeping. The output center is always one row
  // up and one column left of the incoming pixel; whenever that center is
  // interior the incoming column is >= 2, so the two window columns held in
  // registers belong to the same image row and no row-wrap mixing can occur.
  always_comb begin
    col_t = lb1[in_c];
    col_m = lb0[in_c];
    limit = {1'b0, w1_m} + (mode_q ? {1'b0, thr_q} : '0);
    code  = {ge(gray_data, limit), ge(w1_b, limit), ge(w0_b, limit),
             ge(col_m, limit),     ge(w0_m, limit),
             ge(col_t, limit),     ge(w1_t, limit), ge(w0_t, limit)};
    in_slot   = req_d && (in_r != '0) && !((in_r == RW'(1)) && (in_c == '0));
    slot      = req_d ? in_slot : (state == FLUSH);
    interior  = (out_r != '0) && (out_r != RW'(IMG_H - 1)) &&
                (out_c != '0) && (out_c != CW'(IMG_W - 1));
    last_slot = (out_r == RW'(IMG_H - 1)) && (out_c == CW'(IMG_W - 1));
  end

  // Control FSM, request generator, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gray_req  <= 1'b0;
      gray_addr <= '0;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
      finish    <= 1'b0;
      req_d     <= 1'b0;
      mode_q    <= 1'b0;
      thr_q     <= '0;
      in_r      <= '0;
      in_c      <= '0;
      out_r     <= '0;
      out_c     <= '0;
      out_addr  <= '0;
    end else begin
      lbp_valid <= 1'b0;
      req_d     <= gray_req;

      if (req_d) begin
        if (in_c == CW'(IMG_W - 1)) begin
          in_c <= '0;
          in_r <= (in_r == RW'(IMG_H - 1)) ? '0 : in_r + RW'(1);
        end else begin
          in_c <= in_c + CW'(1);
        end
      end

      if (slot) begin
        if (interior) begin
          lbp_valid <= 1'b1;
          lbp_addr  <= out_addr;
          lbp_data  <= code;
        end else if (BORDER_ZERO != 0) begin
          lbp_valid <= 1'b1;
          lbp_addr  <= out_addr;
          lbp_data  <= '0;
        end
        out_addr <= out_addr + ADDR_W'(1);
        if (out_c == CW'(IMG_W - 1)) begin
          out_c <= '0;
          out_r <= (out_r == RW'(IMG_H - 1)) ? '0 : out_r + RW'(1);
        end else begin
          out_c <= out_c + CW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (gray_ready) begin
            state     <= READ;
            gray_req  <= 1'b1;
            gray_addr <= '0;
            mode_q    <= mode;
            thr_q     <= thr;
            in_r      <= '0;
            in_c      <= '0;
            out_r     <= '0;
            out_c     <= '0;
            out_addr  <= '0;
          end
        end
        READ: begin
          if (gray_addr == ADDR_W'(N - 1)) begin
            gray_req <= 1'b0;
            state    <= FLUSH;
          end else begin
            gray_addr <= gray_addr + ADDR_W'(1);
          end
        end
        FLUSH: begin
          if (slot && last_slot) state <= DONE;
        end
        DONE: begin
          finish <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line buffers and window columns; contents are don't-care until filled.
  always_ff @(posedge clk) begin
    if (req_d) begin
      lb1[in_c] <= lb0[in_c];
      lb0[in_c] <= gray_data;
      w0_t <= w1_t;
      w0_m <= w1_m;
      w0_b <= w1_b;
      w1_t <= col_t;
      w1_m <= col_m;
      w1_b <= gray_data;
    end
  end

endmodule

// File: tb/tb_lbp_stream.sv
// Self-checking bench for lbp_stream: three instances (128x128 zero border,
// 4x4 zero border, 4x4 no border writes), a pixel memory model per instance
// and a scoreboard of expected writes built from a reference LBP model.
module tb_lbp_stream;

  logic        clk;
  logic        reset;
  logic [2:0]  rdy;
  logic        mode;
  logic [7:0]  thr;

  logic        b_req, s_req, n_req;
  logic [13:0] b_gaddr, s_gaddr, n_gaddr;
  logic [7:0]  b_data, s_data, n_data;
  logic        b_valid, s_valid, n_valid;
  logic [13:0] b_laddr, s_laddr, n_laddr;
  logic [7:0]  b_ldata, s_ldata, n_ldata;
  logic        b_fin, s_fin, n_fin;

  logic        m_req, m_valid, m_fin;
  logic [13:0] m_gaddr, m_laddr;
  logic [7:0]  m_ldata;

  int sel;
  int pat;
  int cval;
  int ncheck;
  int nfail;

  typedef struct { int addr; int data; } exp_t;
  exp_t sb[$];

  lbp_stream #(.IMG_W(128), .IMG_H(128), .PIX_W(8), .ADDR_W(14), .BORDER_ZERO(1)) u_big (
    .clk(clk), .reset(reset), .gray_ready(rdy[0]), .gray_req(b_req), .gray_addr(b_gaddr),
    .gray_data(b_data), .mode(mode), .thr(thr), .lbp_valid(b_valid), .lbp_addr(b_laddr),
    .lbp_data(b_ldata), .finish(b_fin));

  lbp_stream #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .ADDR_W(14), .BORDER_ZERO(1)) u_small (
    .clk(clk), .reset(reset), .gray_ready(rdy[1]), .gray_req(s_req), .gray_addr(s_gaddr),
    .gray_data(s_data), .mode(mode), .thr(thr), .lbp_valid(s_valid), .lbp_addr(s_laddr),
    .lbp_data(s_ldata), .finish(s_fin));

  lbp_stream #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .ADDR_W(14), .BORDER_ZERO(0)) u_nb (
    .clk(clk), .reset(reset), .gray_ready(rdy[2]), .gray_req(n_req), .gray_addr(n_gaddr),
    .gray_data(n_data), .mode(mode), .thr(thr), .lbp_valid(n_valid), .lbp_addr(n_laddr),
    .lbp_data(n_ldata), .finish(n_fin));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pix(int a);
    case (pat)
      0:       return cval;
      1:       return a & 255;
      default: return ((a * 37) ^ (a >> 3) ^ (a >> 9)) & 255;
    endcase
  endfunction

  // pixel memories: data returned the cycle after each request
  always @(posedge clk) if (b_req) b_data <= 8'(pix(int'(b_gaddr)));
  always @(posedge clk) if (s_req) s_data <= 8'(pix(int'(s_gaddr)));
  always @(posedge clk) if (n_req) n_data <= 8'(pix(int'(n_gaddr)));

  // route the instance under test to the common observation signals
  always_comb begin
    case (sel)
      0: begin m_req = b_req; m_gaddr = b_gaddr; m_valid = b_valid;
               m_laddr = b_laddr; m_ldata = b_ldata; m_fin = b_fin; end
      1: begin m_req = s_req; m_gaddr = s_gaddr; m_valid = s_valid;
               m_laddr = s_laddr; m_ldata = s_ldata; m_fin = s_fin; end
      default: begin m_req = n_req; m_gaddr = n_gaddr; m_valid = n_valid;
               m_laddr = n_laddr; m_ldata = n_ldata; m_fin = n_fin; end
    endcase
  end

  function automatic int model_code(int w, int r, int c, int md, int th);
    int dr [8];
    int dc [8];
    int lim;
    int code;
    dr = '{-1, -1, -1, 0, 0, 1, 1, 1};
    dc = '{-1, 0, 1, -1, 1, -1, 0, 1};
    lim  = pix(r * w + c) + ((md != 0) ? th : 0);
    code = 0;
    for (int i = 0; i < 8; i++)
      if (pix((r + dr[i]) * w + c + dc[i]) >= lim) code = code | (1 << i);
    return code;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    ncheck++;
    assert (got === want)
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic all_zero(input string tag);
    chk(tag, {25'd0, m_req, m_gaddr, m_valid, m_laddr, m_ldata, m_fin}, 64'd0);
  endtask

  task automatic run_frame(input int s, input int w, input int h, input int bz,
                           input int md, input int th, input int abort_at,
                           input int do_reset);
    int   n;
    int   cyc;
    int   fin_cyc;
    int   nreq;
    bit   aborted;
    exp_t e;
    n   = w * h;
    sel = s;
    if (do_reset != 0) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      all_zero("reset_state");
    end
    sb.delete();
    for (int j = 0; j < n; j++) begin
      int r;
      int c;
      r = j / w;
      c = j % w;
      if (r > 0 && r < h - 1 && c > 0 && c < w - 1)
        sb.push_back('{addr: j, data: model_code(w, r, c, md, th)});
      else if (bz != 0)
        sb.push_back('{addr: j, data: 0});
    end
    mode   = md[0];
    thr    = 8'(th);
    rdy[s] = 1'b1;
    cyc     = -1;
    fin_cyc = -1;
    nreq    = 0;
    aborted = 1'b0;
    while (cyc < n + w + 40 && fin_cyc < 0 && !aborted) begin
      @(negedge clk);
      cyc++;
      rdy = '0;
      if (m_req) begin
        chk("req_addr", 64'(m_gaddr), 64'(nreq));
        nreq++;
        if (abort_at >= 0 && nreq - 1 == abort_at) begin
          reset = 1'b1;
          aborted = 1'b1;
        end
      end
      if (!aborted && m_valid) begin
        if (sb.size() == 0) begin
          chk("extra_write", 64'(m_laddr), 64'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("lbp_addr", 64'(m_laddr), 64'(e.addr));
          chk("lbp_data", 64'(m_ldata), 64'(e.data));
          chk("slot_time", 64'(cyc), 64'(e.addr + w + 3));
        end
      end
      if (!aborted && m_fin) fin_cyc = cyc;
    end
    if (aborted) begin
      @(negedge clk);
      all_zero("abort_outputs");
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        all_zero("abort_idle");
      end
    end else begin
      chk("finish_cycle", 64'(fin_cyc), 64'(n + w + 3));
      chk("writes_left", 64'(sb.size()), 64'd0);
      chk("req_count", 64'(nreq), 64'(n));
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("done_hold", {61'd0, m_fin, m_valid, m_req}, 64'b100);
      end
    end
  endtask

  initial begin
    ncheck = 0;
    nfail  = 0;
    sel    = 0;
    reset  = 1'b1;
    rdy    = '0;
    mode   = 1'b0;
    thr    = '0;
    pat    = 0;
    cval   = 0;
    b_data = '0;
    s_data = '0;
    n_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // flat 0x55 image on the full-size instance
    pat = 0; cval = 8'h55;
    run_frame(0, 128, 128, 1, 0, 0, -1, 1);

    // 4x4 ramp, basic compare
    pat = 1;
    run_frame(1, 4, 4, 1, 0, 0, -1, 1);

    // 4x4 ramp, thresholded compare with thr=2
    run_frame(1, 4, 4, 1, 1, 2, -1, 1);

    // 4x4 ramp without border writes
    run_frame(2, 4, 4, 0, 0, 0, -1, 1);

    // saturated image, thr=1: center+thr overflows past max pixel value
    pat = 0; cval = 8'hFF;
    run_frame(1, 4, 4, 1, 1, 1, -1, 1);

    // abort mid-frame, then restart from IDLE without another reset
    pat = 2;
    run_frame(0, 128, 128, 1, 0, 0, 3000, 1);
    run_frame(0, 128, 128, 1, 1, 5, -1, 0);

    $display("%0d/%0d checks passed", ncheck - nfail, ncheck);
    $finish;
  end

endmodule

// File: doc/lbp_stream.md
Name: lbp_stream

Overview:
- Streaming, parametrised Local Binary Pattern engine for the gray-image flow.
- Reads each gray pixel exactly once, in raster order, at one request per cycle.
- Keeps the 3x3 neighbourhood in two internal line buffers plus a window register.
- Emits one LBP code per pixel position, in raster order, to the LBP result memory, with optional zero border and a programmable comparison threshold.

Parameters:
- IMG_W, 128, image width in pixels (>=3).
- IMG_H, 128, image height in pixels (>=3).
- PIX_W, 8, gray pixel bit width.
- ADDR_W, 14, address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- BORDER_ZERO, 1, 1 = emit code 0 at every border address; 0 = border addresses are never written.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- gray_ready  in  1  image available; sampled in IDLE only
- gray_req  out  1  read request, one per pixel
- gray_addr  out  ADDR_W  read address
- gray_data  in  PIX_W  read data, valid the cycle after the request
- mode  in  1  0 = basic compare, 1 = thresholded compare; sampled on frame start
- thr  in  PIX_W  threshold for mode 1; sampled on frame start
- lbp_valid  out  1  write strobe
- lbp_addr  out  ADDR_W  write address (center pixel index r*IMG_W+c)
- lbp_data  out  8  LBP code
- finish  out  1  frame complete

Behaviour:
- Reset: all outputs 0 (gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish); FSM goes to IDLE; line buffers and window are don't-care.
- FSM: IDLE -> READ -> FLUSH -> DONE.
- IDLE: gray_ready=1 moves to READ and latches mode/thr; no other inputs are sampled.
- READ: gray_req=1 every cycle with gray_addr = 0,1,...,N-1 (N=IMG_W*IMG_H). After issuing N-1, gray_req drops and the FSM moves to FLUSH. No stall mechanism: memory must return data each cycle.
- Input k (pixel (r,c)) has gray_data valid in the cycle after its request.
- Neighbour bit order (bit = 1 if neighbour passes compare against center C):
  - bit0 (r-1,c-1), bit1 (r-1,c), bit2 (r-1,c+1)
  - bit3 (r,c-1), bit4 (r,c+1)
  - bit5 (r+1,c-1), bit6 (r+1,c), bit7 (r+1,c+1)
- Compare:
  - mode 0: neighbour >= C.
  - mode 1: neighbour >= C+thr, computed in PIX_W+1 bits with no saturation. C+thr > max pixel value yields bit 0.
- Output ordering: output address j is produced in the cycle after input j+IMG_W+1 is valid (fixed latency, one output per cycle).
  - Interior pixel (1<=r<=IMG_H-2, 1<=c<=IMG_W-2): lbp_valid=1 with the computed code.
  - Border pixel: BORDER_ZERO=1 gives lbp_valid=1, lbp_data=0; BORDER_ZERO=0 gives lbp_valid=0 for that slot (slot still consumed).
- Row wrap: the window must not mix columns IMG_W-1 and 0. Column/row counters wrap at IMG_W-1 and IMG_H-1.
- FLUSH: produces the remaining IMG_W+1 output slots (all border) on consecutive cycles after the last input, then moves to DONE.
- DONE: finish=1 from the cycle after the last output slot; held until reset. gray_req=0, lbp_valid=0.
- lbp_valid is a one-cycle strobe per slot; lbp_addr/lbp_data hold their last values when lbp_valid=0.
- Reset mid-frame: immediate abort. Outputs return to reset values; a new frame starts only from IDLE with gray_ready=1.
- Total cycles from leaving IDLE to finish: N + IMG_W + 3 (±0, checked by the bench).

Test Plan:
- Flat image, all pixels 0x55, mode 0, default params -> every interior lbp_data=0xFF; 16384 writes total; border writes are 0; finish is held.
- IMG_W=IMG_H=4, pixel value = address, mode 0 -> addresses 5,6,9,10 get 0xF0; the other 12 addresses get 0x00; finish asserted N+IMG_W+3=23 cycles after leaving IDLE.
- Same 4x4 ramp, mode 1, thr=2 -> center 5 gives 0xE0 (neighbours >=7 are 8,9,10); center 10 gives 0xE0.
- Same ramp with BORDER_ZERO=0 -> exactly 4 lbp_valid pulses at addresses 5,6,9,10, in raster order, gaps preserved.
- Mode 1, all pixels 0xFF, thr=1 -> all interior codes 0x00 (overflow is not saturated).
- Reset asserted at input 3000 of a 128x128 frame -> all outputs 0 next cycle, FSM in IDLE; re-raising gray_ready restarts from gray_addr 0 and yields a correct full frame.
